// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - 32x32 multiply sequencer over a shared 16x16 registered multiplier
module mul_seq_ctrl #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SIGN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic [63:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [15:0] mul_a_q, mul_a_d;
    logic [15:0] mul_b_q, mul_b_d;
    logic        mul_en_q, mul_en_d;
    // shift code of the partial product currently on the multiplier: 0, 1 (<<16), 2 (<<32)
    logic [1:0]  sh_q, sh_d;

    // tags travel alongside the multiplier pipeline so each product knows its weight
    logic [MUL_LATENCY-1:0] tag_v_q;
    logic [1:0]             tag_sh_q [MUL_LATENCY];

    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [63:0] addend, prod;
    logic [2:0]  n_issue;
    logic        pending;

    assign sign_a = op[1] & src1[31];
    assign sign_b = (op == 2'b11) & src2[31];
    assign mag_a  = sign_a ? (~src1 + 32'd1) : src1;
    assign mag_b  = sign_b ? (~src2 + 32'd1) : src2;
    assign addend = {32'b0, mul_p} << {tag_sh_q[MUL_LATENCY-1], 4'b0000};
    assign prod   = neg_q ? (~acc_q + 64'd1) : acc_q;
    // the high partial product never reaches the low word, so MUL skips it
    assign n_issue = (op_q == 2'b00) ? 3'd3 : 3'd4;

    // tag shift register, one stage per cycle of multiplier latency
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) tag_sh_q[i] <= 2'd0;
        end else begin
            tag_v_q[0]  <= mul_en_q;
            tag_sh_q[0] <= sh_q;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_sh_q[i] <= tag_sh_q[i-1];
            end
        end
    end

    // products still in flight other than the one emerging this cycle
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < MUL_LATENCY - 1; i++) pending = pending | tag_v_q[i];
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            acc_q    <= 64'd0;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            mul_a_q  <= 16'd0;
            mul_b_q  <= 16'd0;
            mul_en_q <= 1'b0;
            sh_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_en_q <= mul_en_d;
            sh_q     <= sh_d;
        end
    end

    // next-state, partial product issue and accumulation
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        mul_en_d = 1'b0;
        sh_d     = sh_q;

        if (tag_v_q[MUL_LATENCY-1]) acc_d = acc_q + addend;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    a_d      = mag_a;
                    b_d      = mag_b;
                    neg_d    = sign_a ^ sign_b;
                    acc_d    = 64'd0;
                    busy_d   = 1'b1;
                    mul_en_d = 1'b1;
                    mul_a_d  = mag_a[15:0];
                    mul_b_d  = mag_b[15:0];
                    sh_d     = 2'd0;
                    cnt_d    = 3'd1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q < n_issue) begin
                    mul_en_d = 1'b1;
                    cnt_d    = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1: begin mul_a_d = a_q[15:0];  mul_b_d = b_q[31:16]; sh_d = 2'd1; end
                        3'd2: begin mul_a_d = a_q[31:16]; mul_b_d = b_q[15:0];  sh_d = 2'd1; end
                        default: begin mul_a_d = a_q[31:16]; mul_b_d = b_q[31:16]; sh_d = 2'd2; end
                    endcase
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pending) state_d = SIGN;
            end
            SIGN: begin
                result_d = (op_q == 2'b00) ? prod[31:0] : prod[63:32];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign mul_en = mul_en_q;

endmodule
